alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Decode/operand stage directly upstream of the RV32I ALU.
- Accepts one instruction per cycle with its PC and register-file read data. Decodes OP, OP-IMM, LUI and AUIPC.
- Presents registered LHS, RHS and 4-bit Function in the ALU's encoding, plus writeback metadata.
- Valid/ready on both sides, with a 2-entry skid buffer so throughput stays at one per cycle under backpressure.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- SKID_DEPTH, 2, entries of buffering; fixed at 2 (output register plus skid register).

Ports:
- Clock  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous active-low reset.
- InValid  input  1  upstream holds a valid instruction.
- InReady  output  1  stage can accept; driven directly from a register.
- Instr  input  32  RV32I instruction word.
- PC  input  32  address of Instr.
- Rs1Data  input  32  register-file value for Instr[19:15].
- Rs2Data  input  32  register-file value for Instr[24:20].
- OutValid  output  1  LHS/RHS/Function/Rd/WriteEnable/Illegal are valid.
- OutReady  input  1  downstream (ALU/writeback) accepts this cycle.
- LHS  output  32  ALU left operand.
- RHS  output  32  ALU right operand.
- Function  output  4  ALU function code.
- Rd  output  5  destination register.
- WriteEnable  output  1  result is to be written to Rd.
- Illegal  output  1  instruction not decodable by this stage.

Behaviour:
- Reset (async, Reset_n low): both skid entries empty.
  - OutValid=0, InReady=1.
  - LHS, RHS, Rd and Function all 0; WriteEnable=0, Illegal=0.
  - Reset mid-transfer drops any in-flight entries.
- Handshakes:
  - Input transfer when InValid&InReady.
  - Output transfer when OutValid&OutReady.
  - Latency is 1 cycle: an instruction accepted at edge N is visible on the outputs after edge N when the buffer is empty.
- Ordering: strict FIFO. The output register is refilled from the skid entry before new input.
- InReady=0 exactly when the skid entry is occupied (both entries full).
  - With one entry held, an input and an output in the same cycle keeps occupancy at 1.
  - Both full plus OutReady=1: the output is drained, skid moves to output, and InReady rises the next cycle.
- Outputs hold stable while OutValid=1 and OutReady=0.
- Decode, by opcode Instr[6:0]:
  - OP 0110011:
    - LHS=Rs1Data, RHS=Rs2Data, Function={Instr[30],funct3}.
    - Legal funct7 is 0000000 for any funct3.
    - 0100000 is legal only with funct3=000 (SUB) or 101 (SRA).
  - OP-IMM 0010011:
    - LHS=Rs1Data, RHS=sign-extended Instr[31:20].
    - Function={1'b0,funct3}, except funct3=101, where Function={Instr[30],101}.
    - Legal imm[11:5] for funct3=001 is 0000000; for 101 it is 0000000 or 0100000.
  - LUI 0110111: LHS=0, RHS={Instr[31:12],12'b0}, Function=0000.
  - AUIPC 0010111: LHS=PC, RHS={Instr[31:12],12'b0}, Function=0000.
- Shift masking: for Function 0001, 0101 and 1101, RHS is forced to {27'b0, shamt[4:0]}, whether shamt comes from register or immediate. The ALU shifts by full RHS, so this is mandatory.
- SLT/SLTU (0010/0011) are emitted as encoded; their implementation belongs to the ALU, not this stage.
- Rd=Instr[11:7]. WriteEnable=1 iff the instruction is legal and Rd≠0.
- Illegal case (any other opcode or bad funct7/imm field):
  - The instruction is still accepted and passed through in order.
  - Illegal=1, WriteEnable=0, Function=0000, LHS=RHS=0, Rd=Instr[11:7].
- No combinational path from OutReady to InReady.

Decomposition:
- Package alu_pkg:
  - Opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC.
  - ALU function codes FN_ADD=0000, FN_SUB=1000, FN_SLL=0001, FN_SLT=0010, FN_SLTU=0011, FN_XOR=0100, FN_SRL=0101, FN_SRA=1101, FN_OR=0110, FN_AND=0111.
  - Packed struct alu_op_t {LHS, RHS, Function, Rd, WriteEnable, Illegal} (75 bits).
- Sub-module alu_skid_buffer: generic 2-entry valid/ready skid buffer over alu_op_t.
- Decode is combinational logic inside alu_operand_stage, feeding the skid buffer.

Test Plan:
- ADD x3,x1,x2 with Rs1Data=5, Rs2Data=7, OutReady=1 -> next cycle OutValid=1, LHS=5, RHS=7, Function=0000, Rd=3, WriteEnable=1, Illegal=0.
- SUB x0,x1,x2 (funct7=0100000) -> Function=1000, WriteEnable=0. SRAI x4,x1,31 with Rs1Data=0x80000000 -> Function=1101, RHS=0x0000001F. SLL with Rs2Data=0xFFFFFF21 -> RHS=0x00000001.
- AUIPC x5,0x12345 at PC=0x00001000 -> LHS=0x00001000, RHS=0x12345000, Function=0000. LUI x6,0xFFFFF -> LHS=0, RHS=0xFFFFF000.
- Opcode 1100011, then OP with funct7=0000001 -> both emitted in order with Illegal=1, WriteEnable=0, LHS=RHS=0.
- Back-to-back stream of 4 ADDs with OutReady held 0 for 3 cycles:
  - The first 2 are accepted; InReady=0 after the second.
  - Outputs are held stable while stalled.
  - On OutReady=1 all 4 emerge in order, with no loss or duplication.
  - Steady OutReady=1 gives 1 transfer per cycle.
- Pull Reset_n low mid-stall with 2 entries held -> immediately OutValid=0, InReady=1, all outputs 0. After release, the next ADD appears with 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stage: opcodes, ALU function
// codes and the operand bundle carried through the skid buffer.
package alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] FN_ADD  = 4'b0000;
    localparam logic [3:0] FN_SUB  = 4'b1000;
    localparam logic [3:0] FN_SLL  = 4'b0001;
    localparam logic [3:0] FN_SLT  = 4'b0010;
    localparam logic [3:0] FN_SLTU = 4'b0011;
    localparam logic [3:0] FN_XOR  = 4'b0100;
    localparam logic [3:0] FN_SRL  = 4'b0101;
    localparam logic [3:0] FN_SRA  = 4'b1101;
    localparam logic [3:0] FN_OR   = 4'b0110;
    localparam logic [3:0] FN_AND  = 4'b0111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // 32 + 32 + 4 + 5 + 1 + 1 = 75 bits
    typedef struct packed {
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [3:0]  func;
        logic [4:0]  rd;
        logic        write_enable;
        logic        illegal;
    } alu_op_t;

    // Shift functions take only the low five bits of the shift amount.
    function automatic logic is_shift(input logic [3:0] func);
        return (func == FN_SLL) || (func == FN_SRL) || (func == FN_SRA);
    endfunction

endpackage

// File: rtl/alu_skid_buffer.sv
// Two-entry valid/ready skid buffer: an output register plus one skid
// register. in_ready comes straight from a flop, so there is no
// combinational path from out_ready back to in_ready.
module alu_skid_buffer
    import alu_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    in_valid,
    output logic    in_ready,
    input  alu_op_t in_data,
    output logic    out_valid,
    input  logic    out_ready,
    output alu_op_t out_data
);

    logic    out_valid_q;
    logic    skid_valid_q;
    logic    in_ready_q;
    alu_op_t out_data_q;
    alu_op_t skid_data_q;
    logic    in_xfer;
    logic    out_free;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_free = ~out_valid_q | out_ready;

    // Output register: refill from skid first to keep FIFO order, else from input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_q <= 1'b1;
                out_data_q  <= skid_data_q;
            end else if (in_xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= in_data;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Skid register catches an input that arrives while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
        end else if (skid_valid_q) begin
            if (out_free) begin
                skid_valid_q <= 1'b0;
                in_ready_q   <= 1'b1;
            end
        end else if (in_xfer && !out_free) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= in_data;
            in_ready_q   <= 1'b0;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/alu_operand_stage.sv
// Decode/operand stage in front of the RV32I ALU. Decodes OP, OP-IMM,
// LUI and AUIPC into ALU operands and function code, then registers the
// result through a two-entry skid buffer.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SKID_DEPTH = 2
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic            InValid,
    output logic            InReady,
    input  logic [31:0]     Instr,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] Rs1Data,
    input  logic [XLEN-1:0] Rs2Data,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [XLEN-1:0] LHS,
    output logic [XLEN-1:0] RHS,
    output logic [3:0]      Function,
    output logic [4:0]      Rd,
    output logic            WriteEnable,
    output logic            Illegal
);

    if (XLEN != 32 || SKID_DEPTH != 2) begin : g_bad_params
        $error("alu_operand_stage supports only XLEN=32 and SKID_DEPTH=2");
    end

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_field;
    alu_op_t    dec;
    alu_op_t    out_op;

    assign opcode   = Instr[6:0];
    assign rd_field = Instr[11:7];
    assign funct3   = Instr[14:12];
    assign funct7   = Instr[31:25];

    // Combinational decode; illegal encodings collapse to zero operands.
    always_comb begin
        logic legal;
        legal            = 1'b0;
        dec              = '0;
        dec.rd           = rd_field;
        unique case (opcode)
            OPC_OP: begin
                legal    = (funct7 == FUNCT7_BASE) ||
                           ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                dec.lhs  = Rs1Data;
                dec.rhs  = Rs2Data;
                dec.func = {Instr[30], funct3};
            end
            OPC_OP_IMM: begin
                dec.lhs  = Rs1Data;
                dec.rhs  = {{20{Instr[31]}}, Instr[31:20]};
                dec.func = {1'b0, funct3};
                legal    = 1'b1;
                if (funct3 == 3'b001) begin
                    legal = (funct7 == FUNCT7_BASE);
                end else if (funct3 == 3'b101) begin
                    legal    = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
                    dec.func = {Instr[30], 3'b101};
                end
            end
            OPC_LUI: begin
                legal    = 1'b1;
                dec.rhs  = {Instr[31:12], 12'b0};
                dec.func = FN_ADD;
            end
            OPC_AUIPC: begin
                legal    = 1'b1;
                dec.lhs  = PC;
                dec.rhs  = {Instr[31:12], 12'b0};
                dec.func = FN_ADD;
            end
            default: legal = 1'b0;
        endcase
        // The ALU shifts by the full RHS, so the shift amount must be trimmed here.
        if (is_shift(dec.func)) begin
            dec.rhs = {27'b0, dec.rhs[4:0]};
        end
        if (!legal) begin
            dec.lhs  = '0;
            dec.rhs  = '0;
            dec.func = FN_ADD;
        end
        dec.illegal      = ~legal;
        dec.write_enable = legal && (rd_field != 5'd0);
    end

    alu_skid_buffer u_skid (
        .clk       (Clock),
        .rst_n     (Reset_n),
        .in_valid  (InValid),
        .in_ready  (InReady),
        .in_data   (dec),
        .out_valid (OutValid),
        .out_ready (OutReady),
        .out_data  (out_op)
    );

    assign LHS         = out_op.lhs;
    assign RHS         = out_op.rhs;
    assign Function    = out_op.func;
    assign Rd          = out_op.rd;
    assign WriteEnable = out_op.write_enable;
    assign Illegal     = out_op.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed cases plus a random
// stream compared against a queue-based reference model.
module tb_alu_operand_stage;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        InValid;
    logic        InReady;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] Rs1Data;
    logic [31:0] Rs2Data;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] LHS;
    logic [31:0] RHS;
    logic [3:0]  Function;
    logic [4:0]  Rd;
    logic        WriteEnable;
    logic        Illegal;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [3:0]  fn;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_op_t;

    exp_op_t q[$];

    alu_operand_stage dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .InValid     (InValid),
        .InReady     (InReady),
        .Instr       (Instr),
        .PC          (PC),
        .Rs1Data     (Rs1Data),
        .Rs2Data     (Rs2Data),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .LHS         (LHS),
        .RHS         (RHS),
        .Function    (Function),
        .Rd          (Rd),
        .WriteEnable (WriteEnable),
        .Illegal     (Illegal)
    );

    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the instruction-set rules.
    function automatic exp_op_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                           input logic [31:0] a, input logic [31:0] b);
        exp_op_t     r;
        logic [6:0]  opc = ins[6:0];
        logic [2:0]  f3  = ins[14:12];
        logic [6:0]  f7  = ins[31:25];
        logic        ok  = 1'b0;
        logic [31:0] imm_i = 32'($signed(ins[31:20]));
        logic [31:0] imm_u = ins & 32'hFFFF_F000;
        r = '{lhs: 0, rhs: 0, fn: 0, rd: ins[11:7], we: 0, ill: 0};
        if (opc == 7'b0110011) begin
            ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            r.lhs = a; r.rhs = b; r.fn = {f7[5], f3};
        end else if (opc == 7'b0010011) begin
            ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
            r.lhs = a; r.rhs = imm_i; r.fn = (f3 == 5) ? {f7[5], f3} : {1'b0, f3};
        end else if (opc == 7'b0110111) begin
            ok = 1'b1; r.rhs = imm_u;
        end else if (opc == 7'b0010111) begin
            ok = 1'b1; r.lhs = pc; r.rhs = imm_u;
        end
        if (r.fn == 4'd1 || r.fn == 4'd5 || r.fn == 4'd13) r.rhs = r.rhs % 32;
        if (!ok) begin r.lhs = 0; r.rhs = 0; r.fn = 0; end
        r.ill = !ok;
        r.we  = ok && (r.rd != 0);
        return r;
    endfunction

    task automatic compare_outputs();
        check_eq("out_valid", 32'(OutValid), 32'(q.size() != 0));
        check_eq("in_ready", 32'(InReady), 32'(q.size() < 2));
        if (q.size() != 0) begin
            check_eq("lhs", LHS, q[0].lhs);
            check_eq("rhs", RHS, q[0].rhs);
            check_eq("function", 32'(Function), 32'(q[0].fn));
            check_eq("rd", 32'(Rd), 32'(q[0].rd));
            check_eq("write_enable", 32'(WriteEnable), 32'(q[0].we));
            check_eq("illegal", 32'(Illegal), 32'(q[0].ill));
        end
    endtask

    // One clock: drive at negedge, update the model at posedge, check at next negedge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b, input logic ordy,
                        output logic accepted);
        logic in_x, out_x;
        InValid = v; Instr = ins; PC = pc; Rs1Data = a; Rs2Data = b; OutReady = ordy;
        in_x  = v && (q.size() < 2);
        out_x = ordy && (q.size() != 0);
        @(posedge Clock);
        if (out_x) void'(q.pop_front());
        if (in_x) q.push_back(ref_decode(ins, pc, a, b));
        @(negedge Clock);
        compare_outputs();
        accepted = in_x;
    endtask

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins = $urandom;
        logic [6:0]  opcs [5] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1100011};
        int          k = $urandom_range(0, 5);
        ins[6:0] = (k < 5) ? opcs[k] : 7'($urandom);
        case ($urandom_range(0, 3))
            0: ins[31:25] = 7'h00;
            1: ins[31:25] = 7'h20;
            default: ;
        endcase
        return ins;
    endfunction

    initial begin
        logic        acc;
        logic [31:0] add_i [4];
        logic [31:0] ins;
        logic [31:0] pc, a, b;
        logic        v;
        int          idx;
        int          cyc;

        Reset_n = 1'b0; InValid = 0; Instr = 0; PC = 0; Rs1Data = 0; Rs2Data = 0; OutReady = 0;
        repeat (2) @(negedge Clock);
        compare_outputs();
        check_eq("reset_lhs", LHS, 0);
        check_eq("reset_we_ill", {WriteEnable, Illegal}, 0);
        Reset_n = 1'b1;
        @(negedge Clock);
        compare_outputs();

        // ADD x3,x1,x2
        step(1, r_type(7'h00, 2, 1, 3'b000, 3, 7'h33), 0, 5, 7, 1, acc);
        check_eq("add_valid", 32'(OutValid), 1);
        check_eq("add_lhs", LHS, 5);
        check_eq("add_rhs", RHS, 7);
        check_eq("add_fn", 32'(Function), 0);
        check_eq("add_rd", 32'(Rd), 3);
        check_eq("add_we_ill", {WriteEnable, Illegal}, 2);
        // SUB x0,x1,x2
        step(1, r_type(7'h20, 2, 1, 3'b000, 0, 7'h33), 0, 9, 4, 1, acc);
        check_eq("sub_fn", 32'(Function), 4'b1000);
        check_eq("sub_we", 32'(WriteEnable), 0);
        // SRAI x4,x1,31
        step(1, r_type(7'h20, 31, 1, 3'b101, 4, 7'h13), 0, 32'h8000_0000, 0, 1, acc);
        check_eq("srai_fn", 32'(Function), 4'b1101);
        check_eq("srai_rhs", RHS, 32'h1F);
        // SLL x1,x2,x3 with large shift register
        step(1, r_type(7'h00, 3, 2, 3'b001, 1, 7'h33), 0, 1, 32'hFFFF_FF21, 1, acc);
        check_eq("sll_rhs", RHS, 1);
        // AUIPC x5,0x12345
        step(1, {20'h12345, 5'd5, 7'h17}, 32'h1000, 0, 0, 1, acc);
        check_eq("auipc_lhs", LHS, 32'h1000);
        check_eq("auipc_rhs", RHS, 32'h1234_5000);
        // LUI x6,0xFFFFF
        step(1, {20'hFFFFF, 5'd6, 7'h37}, 32'h1000, 3, 3, 1, acc);
        check_eq("lui_lhs", LHS, 0);
        check_eq("lui_rhs", RHS, 32'hFFFF_F000);
        // Illegal opcode, then OP with funct7=0000001
        step(1, r_type(7'h00, 2, 1, 3'b000, 7, 7'h63), 0, 5, 7, 1, acc);
        check_eq("ill_opc", {Illegal, WriteEnable}, 2);
        check_eq("ill_opc_ops", LHS | RHS, 0);
        step(1, r_type(7'h01, 2, 1, 3'b000, 8, 7'h33), 0, 5, 7, 1, acc);
        check_eq("ill_f7", {Illegal, WriteEnable}, 2);
        check_eq("ill_f7_rd", 32'(Rd), 8);
        step(0, 0, 0, 0, 0, 1, acc);

        // Four back-to-back ADDs with OutReady low for three cycles
        for (int i = 0; i < 4; i++) add_i[i] = r_type(7'h00, 2, 1, 3'b000, 5'(10 + i), 7'h33);
        idx = 0; cyc = 0;
        while (idx < 4 && cyc < 50) begin
            step(1, add_i[idx], 0, 32'(100 + idx), 1, cyc >= 3, acc);
            if (acc) idx++;
            if (cyc == 1) check_eq("stall_in_ready", 32'(InReady), 0);
            if (cyc == 2) check_eq("stall_hold_lhs", LHS, 100);
            cyc++;
        end
        check_eq("stream_all_accepted", idx, 4);
        repeat (3) step(0, 0, 0, 0, 0, 1, acc);

        // Reset while holding two entries
        step(1, add_i[0], 0, 1, 2, 0, acc);
        step(1, add_i[1], 0, 3, 4, 0, acc);
        #2 Reset_n = 1'b0;
        #1;
        q.delete();
        check_eq("rst_mid_valid", 32'(OutValid), 0);
        check_eq("rst_mid_ready", 32'(InReady), 1);
        check_eq("rst_mid_ops", LHS | RHS | 32'(Function) | 32'(Rd), 0);
        check_eq("rst_mid_flags", {WriteEnable, Illegal}, 0);
        @(negedge Clock);
        Reset_n = 1'b1;
        step(1, add_i[2], 0, 42, 1, 1, acc);
        check_eq("post_rst_valid", 32'(OutValid), 1);
        check_eq("post_rst_lhs", LHS, 42);

        // Random stream; instructions stay put until accepted
        ins = rand_instr(); pc = $urandom; a = $urandom; b = $urandom; v = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!v || acc) begin
                v = ($urandom_range(0, 3) != 0);
                ins = rand_instr(); pc = $urandom; a = $urandom; b = $urandom;
            end
            step(v, ins, pc, a, b, $urandom_range(0, 3) != 0, acc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
